// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: occupancy state of an elastic
// inter-stage register, used by every stage and the hazard unit.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pstate_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Number of entries held in a given state.
  function automatic logic [1:0] occ_of(pstate_e s);
    logic [1:0] o;
    o = OCC_EMPTY;
    unique case (s)
      PS_EMPTY: o = OCC_EMPTY;
      PS_BUSY:  o = OCC_BUSY;
      PS_FULL:  o = OCC_FULL;
      default:  o = OCC_EMPTY;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Holds at all-ones once reached; only rst or clear brings it back.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] r_cnt;
  logic         w_inc;

  assign w_inc = i_en && (r_cnt != CNT_MAX);

  // count enabled cycles, stop at the maximum
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (w_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/elastic_pipe_stage.sv
// Elastic inter-stage register: valid/ready handshake, flush,
// optional 2-entry skid buffer and saturating stall counter.
module elastic_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter bit SKID        = 1'b1,
  parameter bit RESET_DATA  = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pstate_e           r_state;
  pstate_e           w_state_nxt;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_ld;
  logic              w_main_from_skid;
  logic              w_skid_ld;
  logic              w_stall;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_skid_q;
  logic [DATA_W-1:0] w_main_d;
  logic [1:0]        r_occ;

  assign w_out_valid = (r_state != PS_EMPTY);
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = w_out_valid && out_ready;
  assign w_stall     = w_out_valid && !out_ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PS_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state: flush empties the stage, else fill/drain
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = PS_EMPTY;
    end else begin
      unique case (r_state)
        PS_EMPTY: begin
          if (w_in_fire) w_state_nxt = PS_BUSY;
        end
        PS_BUSY: begin
          if (w_in_fire && !w_out_fire && SKID)
            w_state_nxt = PS_FULL;
          else if (!w_in_fire && w_out_fire)
            w_state_nxt = PS_EMPTY;
        end
        PS_FULL: begin
          if (w_out_fire) w_state_nxt = PS_BUSY;
        end
        default: w_state_nxt = PS_EMPTY;
      endcase
    end
  end

  // outputs: register load strobes per state
  always_comb begin
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    unique case (r_state)
      PS_EMPTY: begin
        w_main_ld = w_in_fire;
      end
      PS_BUSY: begin
        w_main_ld = w_in_fire && w_out_fire;
        w_skid_ld = w_in_fire && !w_out_fire;
      end
      PS_FULL: begin
        w_main_ld        = w_out_fire;
        w_main_from_skid = 1'b1;
      end
      default: begin
        w_main_ld = 1'b0;
      end
    endcase
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

  // main entry: loads only on accept/advance, so it stays stable under stall
  always_ff @(posedge clk) begin
    if (RESET_DATA && (rst || flush)) begin
      r_main <= '0;
    end else if (w_main_ld && !flush) begin
      r_main <= w_main_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic              r_in_ready;
      logic [DATA_W-1:0] r_skid;

      // in_ready is a flop so out_ready never reaches it combinationally
      always_ff @(posedge clk) begin
        if (rst) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != PS_FULL);
        end
      end

      // skid entry catches the beat that arrives while main is stalled
      always_ff @(posedge clk) begin
        if (RESET_DATA && (rst || flush)) begin
          r_skid <= '0;
        end else if (w_skid_ld && !flush) begin
          r_skid <= in_data;
        end
      end

      assign w_in_ready = r_in_ready || flush;
      assign w_skid_q   = r_skid;
    end else begin : g_noskid
      logic w_unused;

      assign w_unused   = w_skid_ld;
      assign w_in_ready = !w_out_valid || out_ready || flush;
      assign w_skid_q   = '0;
    end
  endgenerate

  // occupancy tracks the next state so it is registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= OCC_EMPTY;
    end else begin
      r_occ <= occ_of(w_state_nxt);
    end
  end

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (1'b0),
    .i_en  (w_stall),
    .o_cnt (stall_cnt)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Directed bench for elastic_pipe_stage: SKID=1 table, SKID=0
// combinational ready sequence, 4-bit stall counter saturation.
module tb_elastic_pipe_stage;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // DUT A: SKID=1, 16-bit stall counter
  logic       a_fl, a_iv, a_ir, a_ov, a_or;
  logic [7:0] a_d, a_od;
  logic [1:0] a_occ;
  logic [15:0] a_st;

  // DUT B: SKID=0
  logic       b_fl, b_iv, b_ir, b_ov, b_or;
  logic [7:0] b_d, b_od;
  logic [1:0] b_occ;
  logic [15:0] b_st;

  // DUT C: SKID=1, 4-bit stall counter
  logic       c_fl, c_iv, c_ir, c_ov, c_or;
  logic [7:0] c_d, c_od;
  logic [1:0] c_occ;
  logic [3:0] c_st;

  elastic_pipe_stage #(
    .DATA_W(8), .SKID(1'b1), .RESET_DATA(1'b1), .STALL_CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst), .flush(a_fl),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .occupancy(a_occ), .stall_cnt(a_st)
  );

  elastic_pipe_stage #(
    .DATA_W(8), .SKID(1'b0), .RESET_DATA(1'b1), .STALL_CNT_W(16)
  ) u_b (
    .clk(clk), .rst(rst), .flush(b_fl),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .occupancy(b_occ), .stall_cnt(b_st)
  );

  elastic_pipe_stage #(
    .DATA_W(8), .SKID(1'b1), .RESET_DATA(1'b1), .STALL_CNT_W(4)
  ) u_c (
    .clk(clk), .rst(rst), .flush(c_fl),
    .in_valid(c_iv), .in_ready(c_ir), .in_data(c_d),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
    .occupancy(c_occ), .stall_cnt(c_st)
  );

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  occ;
    logic        ir;
    logic [15:0] st;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got 0x%0h want 0x%0h", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(logic iv, logic [7:0] d, logic ordy,
                              logic fl, logic ov, logic [7:0] od,
                              logic [1:0] occ, logic ir,
                              logic [15:0] st);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.od = od; v.occ = occ; v.ir = ir; v.st = st;
    return v;
  endfunction

  initial begin
    //             iv d      or fl   ov od     occ ir st
    // streaming
    tbl[0]  = mk(1, 8'h11, 1, 0,   1, 8'h11, 1, 1, 0);
    tbl[1]  = mk(1, 8'h22, 1, 0,   1, 8'h22, 1, 1, 0);
    tbl[2]  = mk(1, 8'h33, 1, 0,   1, 8'h33, 1, 1, 0);
    tbl[3]  = mk(0, 8'h00, 1, 0,   0, 8'h33, 0, 1, 0);
    // back-pressure into skid
    tbl[4]  = mk(1, 8'h0A, 0, 0,   1, 8'h0A, 1, 1, 0);
    tbl[5]  = mk(1, 8'h0B, 0, 0,   1, 8'h0A, 2, 0, 1);
    tbl[6]  = mk(1, 8'h0D, 0, 0,   1, 8'h0A, 2, 0, 2);
    tbl[7]  = mk(0, 8'h00, 1, 0,   1, 8'h0B, 1, 1, 2);
    tbl[8]  = mk(0, 8'h00, 1, 0,   0, 8'h0B, 0, 1, 2);
    // flush while full, with a beat offered in the flush cycle
    tbl[9]  = mk(1, 8'h01, 0, 0,   1, 8'h01, 1, 1, 2);
    tbl[10] = mk(1, 8'h02, 0, 0,   1, 8'h01, 2, 0, 3);
    tbl[11] = mk(1, 8'h0C, 0, 1,   0, 8'h00, 0, 1, 4);
    tbl[12] = mk(0, 8'h00, 1, 0,   0, 8'h00, 0, 1, 4);
    tbl[13] = mk(1, 8'h44, 1, 0,   1, 8'h44, 1, 1, 4);
    // flush with out_fire in the same cycle
    tbl[14] = mk(0, 8'h00, 0, 0,   1, 8'h44, 1, 1, 5);
    tbl[15] = mk(0, 8'h00, 1, 1,   0, 8'h00, 0, 1, 5);

    a_fl = 0; b_fl = 0; c_fl = 0;
    a_or = 0; b_or = 0; c_or = 0;

    // reset with in_valid asserted throughout
    rst = 1'b1;
    a_iv = 1; a_d = 8'h77;
    b_iv = 1; b_d = 8'h77;
    c_iv = 1; c_d = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov",   0, 32'(a_ov),   0);
    chk("rst_occ",  0, 32'(a_occ),  0);
    chk("rst_st",   0, 32'(a_st),   0);
    chk("rst_od",   0, 32'(a_od),   0);
    chk("rst_b_ov", 0, 32'(b_ov),   0);
    rst = 1'b0;
    a_iv = 0; b_iv = 0; c_iv = 0;
    @(posedge clk);
    #1;
    chk("post_rst_ir",  0, 32'(a_ir),  1);
    chk("post_rst_ov",  0, 32'(a_ov),  0);
    chk("post_rst_occ", 0, 32'(a_occ), 0);

    // table on DUT A
    for (int i = 0; i < NV; i++) begin
      a_iv = tbl[i].iv;
      a_d  = tbl[i].d;
      a_or = tbl[i].ordy;
      a_fl = tbl[i].fl;
      @(posedge clk);
      #1;
      chk("a_ov",  i, 32'(a_ov),  32'(tbl[i].ov));
      chk("a_od",  i, 32'(a_od),  32'(tbl[i].od));
      chk("a_occ", i, 32'(a_occ), 32'(tbl[i].occ));
      chk("a_ir",  i, 32'(a_ir),  32'(tbl[i].ir));
      chk("a_st",  i, 32'(a_st),  32'(tbl[i].st));
    end
    a_iv = 0; a_fl = 0; a_or = 0;

    // SKID=0: combinational in_ready and simultaneous replace
    b_iv = 1; b_d = 8'h05; b_or = 0;
    @(posedge clk);
    #1;
    chk("b_ov_load",  0, 32'(b_ov),  1);
    chk("b_od_load",  0, 32'(b_od),  8'h05);
    chk("b_occ_load", 0, 32'(b_occ), 1);
    chk("b_ir_stall", 0, 32'(b_ir),  0);
    b_d = 8'h06;
    @(posedge clk);
    #1;
    chk("b_od_hold",  1, 32'(b_od),  8'h05);
    chk("b_ir_hold",  1, 32'(b_ir),  0);
    chk("b_st_hold",  1, 32'(b_st),  1);
    b_or = 1;
    #1;
    chk("b_ir_comb",  2, 32'(b_ir),  1);
    @(posedge clk);
    #1;
    chk("b_od_repl",  3, 32'(b_od),  8'h06);
    chk("b_ov_repl",  3, 32'(b_ov),  1);
    chk("b_occ_repl", 3, 32'(b_occ), 1);
    b_iv = 0;
    @(posedge clk);
    #1;
    chk("b_ov_drain",  4, 32'(b_ov),  0);
    chk("b_occ_drain", 4, 32'(b_occ), 0);

    // 4-bit stall counter saturation
    c_iv = 1; c_d = 8'h09; c_or = 0;
    @(posedge clk);
    #1;
    c_iv = 0;
    chk("c_st_start", 0, 32'(c_st), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("c_st_10", 1, 32'(c_st), 10);
    repeat (10) @(posedge clk);
    #1;
    chk("c_st_sat", 2, 32'(c_st), 15);
    chk("c_ov",     2, 32'(c_ov), 1);
    chk("c_od",     2, 32'(c_od), 8'h09);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
